dmem_responder: RTL

//  Data-memory responder serving the MEM stage of the pipelined processor.

---
 rtl/dmem_responder_pkg.sv | 16 +
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default
// widths and byte-enable/counter sizes.
package dmem_responder_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int BE_W       = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage : dmem_responder_pkg

// File: rtl/dmem_array.sv
// DEPTH x DATA_W synchronous RAM with per-byte write enables and a
// registered read port; one access per enabled cycle.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // NOTE: the storage array has no reset; clearing a RAM would force it
  // into flops, and nothing depends on its power-up contents.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) r_mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[widx];
      end
    end
  end

  assign rdata = r_rdata;

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one request per handshake, waits
// WAIT_STATES cycles, then returns a single-cycle response and drives stall.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam int IDX_W     = $clog2(DEPTH);
  localparam bit ZERO_WAIT = (WAIT_STATES == 0);

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_accept, w_enter_resp;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;

  logic              w_acc_we;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic [BE_W-1:0]   w_acc_be;
  logic              w_err, w_ram_en;
  logic [DATA_W-1:0] w_ram_rdata;

  logic              r_rsp_valid, r_rsp_load, r_rsp_err;

  assign w_accept = (r_state == ST_IDLE) && req_valid;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (ZERO_WAIT) begin
            w_state_nxt  = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt  = ST_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  // With no wait states the RESP edge is the accept edge, so the access
  // must use the live request instead of the not-yet-latched copy.
  assign w_acc_we    = ZERO_WAIT ? req_we    : r_we;
  assign w_acc_addr  = ZERO_WAIT ? req_addr  : r_addr;
  assign w_acc_wdata = ZERO_WAIT ? req_wdata : r_wdata;
  assign w_acc_be    = ZERO_WAIT ? req_be    : r_be;

  assign w_err    = (w_acc_addr[1:0] != 2'b00) || ((w_acc_addr >> (IDX_W + 2)) != '0);
  assign w_ram_en = w_enter_resp && !w_err;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (w_ram_en),
    .we    (w_acc_we),
    .be    (w_acc_be),
    .widx  (w_acc_addr[IDX_W+1:2]),
    .wdata (w_acc_wdata),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_load  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_enter_resp;
      r_rsp_load  <= w_enter_resp && !w_err && !w_acc_we;
      r_rsp_err   <= w_enter_resp && w_err;
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_load ? w_ram_rdata : '0;
  assign stall     = req_valid && !r_rsp_valid;

endmodule : dmem_responder
